// File: rtl/dsi_byte_distributor_if.sv
// dsi_byte_distributor_if: packet word input stream and per-lane FIFO read side
// of the DSI byte distributor.
interface dsi_byte_distributor_if;
    logic [31:0] in_data;
    logic [3:0]  in_strb;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [35:0] lane_fifo_data;
    logic [3:0]  lane_fifo_empty;
    logic [3:0]  lane_fifo_read;
    logic        busy;
    modport master (
        output in_data, in_strb, in_valid, in_last, lane_fifo_read,
        input  in_ready, lane_fifo_data, lane_fifo_empty, busy
    );
    modport slave (
        input  in_data, in_strb, in_valid, in_last, lane_fifo_read,
        output in_ready, lane_fifo_data, lane_fifo_empty, busy
    );
endinterface

// File: rtl/dsi_byte_distributor.sv
// dsi_byte_distributor: spreads strobed packet bytes round-robin over 1..4 lane
// FIFOs, one group per cycle, and closes each packet with an EOP entry per lane.
module dsi_byte_distributor #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic [1:0]             reg_lanes_number,
    dsi_byte_distributor_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DISP = 2'd1;
    localparam logic [1:0] S_EOP  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      mask_q, mask_d;
    logic            last_q, last_d;
    logic            pkt_q, pkt_d;
    logic [1:0]      lanes_q, lanes_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [3:0]      grp_en, mask_left, act, full, wr_en;
    logic [3:0][8:0] grp_entry;
    logic [2:0]      l3, grp_j, grp_lane, cnt_sum;
    logic [1:0]      cnt_nx;
    logic            grp_ok, eop_ok, acc, load;

    assign l3 = {1'b0, lanes_q} + 3'd1;
    assign act = 4'b1111 >> (2'd3 - lanes_q);

    // Take up to L remaining bytes in ascending order; lane = (cnt + j) mod L.
    always_comb begin
        grp_en = '0;
        grp_entry = '0;
        mask_left = mask_q;
        grp_j = '0;
        grp_lane = '0;
        for (int k = 0; k < 4; k++) begin
            grp_lane = grp_j + {1'b0, cnt_q};
            grp_lane = grp_lane >= l3 ? grp_lane - l3 : grp_lane;
            if (mask_q[k] && grp_j < l3) begin
                grp_en[grp_lane[1:0]] = 1'b1;
                grp_entry[grp_lane[1:0]] = {1'b0, data_q[8*k +: 8]};
                mask_left[k] = 1'b0;
                grp_j = grp_j + 3'd1;
            end
        end
        cnt_sum = grp_j + {1'b0, cnt_q};
        cnt_nx = cnt_sum >= l3 ? 2'(cnt_sum - l3) : cnt_sum[1:0];
    end

    // Full is taken from the registered pointers, so same-edge pops never unblock a write.
    assign grp_ok = ~|(grp_en & full);
    assign eop_ok = ~|(act & full);
    assign wr_en = (state_q == S_DISP && grp_ok) ? grp_en :
                   (state_q == S_EOP && eop_ok) ? act : 4'b0;

    assign bus.in_ready = rst_n && (state_q == S_IDLE ||
                          (state_q == S_DISP && grp_ok && mask_left == 4'b0 && !last_q));
    assign bus.busy = state_q != S_IDLE;
    assign acc = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        data_d = data_q;
        mask_d = mask_q;
        last_d = last_q;
        pkt_d = pkt_q;
        lanes_d = lanes_q;
        cnt_d = cnt_q;
        load = 1'b0;
        case (state_q)
            S_IDLE: load = acc;
            S_DISP: if (grp_ok) begin
                mask_d = mask_left;
                cnt_d = cnt_nx;
                if (mask_left == 4'b0) begin
                    state_d = last_q ? S_EOP : S_IDLE;
                    load = acc;
                end
            end
            S_EOP: if (eop_ok) begin
                state_d = S_IDLE;
                pkt_d = 1'b0;
                cnt_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            data_d = bus.in_data;
            mask_d = bus.in_strb;
            last_d = bus.in_last;
            pkt_d = 1'b1;
            lanes_d = pkt_q ? lanes_q : reg_lanes_number;
            state_d = |bus.in_strb ? S_DISP : bus.in_last ? S_EOP : S_IDLE;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q <= '0;
            mask_q <= '0;
            last_q <= 1'b0;
            pkt_q <= 1'b0;
            lanes_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            data_q <= data_d;
            mask_q <= mask_d;
            last_q <= last_d;
            pkt_q <= pkt_d;
            lanes_q <= lanes_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [8:0]  mem [FIFO_DEPTH];
        logic [AW:0] wp_q, rp_q;
        logic        empty, pop;
        assign empty = wp_q == rp_q;
        assign full[i] = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
        assign pop = bus.lane_fifo_read[i] && !empty;
        assign bus.lane_fifo_empty[i] = empty;
        assign bus.lane_fifo_data[9*i +: 9] = empty ? 9'h000 : mem[rp_q[AW-1:0]];
        always_ff @(posedge clk_sys or negedge rst_n) begin
            if (!rst_n) begin
                wp_q <= '0;
                rp_q <= '0;
            end else begin
                if (wr_en[i]) wp_q <= wp_q + (AW+1)'(1);
                if (pop) rp_q <= rp_q + (AW+1)'(1);
            end
        end
        always_ff @(posedge clk_sys) begin
            if (wr_en[i]) mem[wp_q[AW-1:0]] <= state_q == S_EOP ? 9'h100 : grp_entry[i];
        end
    end
endmodule

// File: tb/tb_dsi_byte_distributor.sv
// tb_dsi_byte_distributor: directed scenarios plus randomized traffic scored
// against a packet-level per-lane queue model.
module tb_dsi_byte_distributor;
    localparam int DEPTH = 8;

    logic       clk_sys = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] reg_lanes_number = 2'd0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [8:0] exp_q [4][$];
    bit         m_pkt = 1'b0;
    int         m_l = 1;
    int         m_n = 0;
    int         w;

    dsi_byte_distributor_if bus();

    dsi_byte_distributor #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_sys(clk_sys),
        .rst_n(rst_n),
        .reg_lanes_number(reg_lanes_number),
        .bus(bus)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(negedge clk_sys);
        #1;
    endtask

    // Packet-level reference: byte n of a packet goes to lane n mod L, EOP on lanes < L.
    function automatic void model_accept(input logic [31:0] d, input logic [3:0] s, input logic l);
        if (!m_pkt) begin
            m_pkt = 1'b1;
            m_l = int'(reg_lanes_number) + 1;
            m_n = 0;
        end
        for (int k = 0; k < 4; k++) begin
            if (s[k]) begin
                exp_q[m_n % m_l].push_back({1'b0, d[8*k +: 8]});
                m_n++;
            end
        end
        if (l) begin
            for (int i = 0; i < m_l; i++) exp_q[i].push_back(9'h100);
            m_pkt = 1'b0;
        end
    endfunction

    function automatic void model_reset;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        m_pkt = 1'b0;
    endfunction

    task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l, output int wt);
        bus.in_data = d;
        bus.in_strb = s;
        bus.in_last = l;
        bus.in_valid = 1'b1;
        wt = 0;
        while (!bus.in_ready && wt < 200) begin
            nxt;
            wt++;
        end
        chk("send_accept", bus.in_ready, 1);
        if (bus.in_ready) model_accept(d, s, l);
        nxt;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_pops(input logic [3:0] r, input string tag);
        for (int i = 0; i < 4; i++) begin
            if (r[i] && !bus.lane_fifo_empty[i]) begin
                chk({tag, "_avail"}, bus.lane_fifo_empty[i], exp_q[i].size() == 0);
                if (exp_q[i].size() != 0) chk({tag, "_pop"}, bus.lane_fifo_data[9*i +: 9], exp_q[i].pop_front());
            end
        end
    endtask

    task automatic popc(input logic [3:0] r, input string tag);
        check_pops(r, tag);
        bus.lane_fifo_read = r;
        nxt;
        bus.lane_fifo_read = 4'b0;
    endtask

    task automatic pop_exp(input int i, input logic [8:0] e);
        chk($sformatf("lane%0d_head", i), bus.lane_fifo_data[9*i +: 9], e);
        popc(4'b0001 << i, $sformatf("lane%0d", i));
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (bus.busy && t < 200) begin
            nxt;
            t++;
        end
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((bus.busy || bus.lane_fifo_empty != 4'hF) && t < 500) begin
            popc(4'hF, tag);
            t++;
        end
        chk({tag, "_empty"}, bus.lane_fifo_empty, 4'hF);
        chk({tag, "_left"}, exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        logic [3:0] rd;
        int words_left;
        bit acc;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_strb = '0;
        bus.in_last = 1'b0;
        bus.lane_fifo_read = '0;
        nxt;
        nxt;
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_empty", bus.lane_fifo_empty, 4'hF);
        chk("rst_data", bus.lane_fifo_data, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", bus.in_ready, 1);
        nxt;

        // Four lanes, one full word: bytes land one edge after accept, EOP one edge later.
        reg_lanes_number = 2'd3;
        send(32'h44332211, 4'hF, 1'b1, w);
        chk("l4_not_yet", bus.lane_fifo_empty, 4'hF);
        chk("l4_busy", bus.busy, 1);
        nxt;
        chk("l4_data", bus.lane_fifo_data, {1'b0, 8'h44, 1'b0, 8'h33, 1'b0, 8'h22, 1'b0, 8'h11});
        chk("l4_eop_ready", bus.in_ready, 0);
        nxt;
        chk("l4_done", bus.busy, 0);
        popc(4'hF, "l4");
        chk("l4_eop", bus.lane_fifo_data, {4{9'h100}});
        popc(4'hF, "l4e");
        chk("l4_empty", bus.lane_fifo_empty, 4'hF);

        // One lane: byte-per-cycle serialisation.
        reg_lanes_number = 2'd0;
        send(32'hDDCCBBAA, 4'hF, 1'b0, w);
        send(32'h000000EE, 4'h1, 1'b1, w);
        chk("l1_ready_gap", w, 3);
        wait_idle("l1");
        chk("l1_lanes", bus.lane_fifo_empty, 4'b1110);
        pop_exp(0, 9'h0AA);
        pop_exp(0, 9'h0BB);
        pop_exp(0, 9'h0CC);
        pop_exp(0, 9'h0DD);
        pop_exp(0, 9'h0EE);
        pop_exp(0, 9'h100);
        chk("l1_empty", bus.lane_fifo_empty, 4'hF);

        // Three lanes, seven bytes spanning two words.
        reg_lanes_number = 2'd2;
        send(32'h04030201, 4'hF, 1'b0, w);
        send(32'h00070605, 4'h7, 1'b1, w);
        wait_idle("l3");
        pop_exp(0, 9'h001);
        pop_exp(0, 9'h004);
        pop_exp(0, 9'h007);
        pop_exp(0, 9'h100);
        pop_exp(1, 9'h002);
        pop_exp(1, 9'h005);
        pop_exp(1, 9'h100);
        pop_exp(2, 9'h003);
        pop_exp(2, 9'h006);
        pop_exp(2, 9'h100);
        chk("l3_empty", bus.lane_fifo_empty, 4'hF);

        // Sparse strobes, then zero-strobe words.
        reg_lanes_number = 2'd1;
        send(32'hDDCCBBAA, 4'b1010, 1'b1, w);
        wait_idle("sp");
        pop_exp(0, 9'h0BB);
        pop_exp(1, 9'h0DD);
        pop_exp(0, 9'h100);
        pop_exp(1, 9'h100);
        send(32'h12345678, 4'h0, 1'b0, w);
        chk("z_nothing", bus.lane_fifo_empty, 4'hF);
        chk("z_busy", bus.busy, 0);
        send(32'h0, 4'h0, 1'b1, w);
        wait_idle("z");
        chk("z_eop_lanes", bus.lane_fifo_empty, 4'b1100);
        pop_exp(0, 9'h100);
        pop_exp(1, 9'h100);
        chk("z_empty", bus.lane_fifo_empty, 4'hF);

        // Lane 1 full: the two-byte group must stall as a whole until one pop.
        reg_lanes_number = 2'd1;
        for (int k = 0; k < DEPTH / 2; k++) send($urandom, 4'hF, 1'b0, w);
        wait_idle("fill");
        chk("fill_lanes", bus.lane_fifo_empty, 4'b1100);
        for (int k = 0; k < DEPTH; k++) popc(4'b0001, "fill0");
        chk("fill_l0_empty", bus.lane_fifo_empty, 4'b1101);
        send(32'h0000BBAA, 4'b0011, 1'b1, w);
        nxt;
        nxt;
        chk("stall_l0", bus.lane_fifo_empty, 4'b1101);
        chk("stall_busy", bus.busy, 1);
        popc(4'b0010, "unstall");
        chk("stall_after_pop", bus.lane_fifo_empty[0], 1);
        nxt;
        chk("unstall_l0", bus.lane_fifo_empty[0], 0);
        chk("unstall_data", bus.lane_fifo_data[8:0], 9'h0AA);
        drain("stall");

        // Reset while three bytes are still held.
        reg_lanes_number = 2'd0;
        send(32'h11223344, 4'hF, 1'b0, w);
        nxt;
        chk("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", bus.lane_fifo_empty, 4'hF);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.in_ready, 0);
        chk("mid_rst_data", bus.lane_fifo_data, 0);
        model_reset();
        nxt;
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", bus.in_ready, 1);
        nxt;
        reg_lanes_number = 2'd3;
        send(32'hA4A3A2A1, 4'hF, 1'b1, w);
        wait_idle("post_rst");
        chk("post_rst_l0", bus.lane_fifo_data[8:0], 9'h0A1);
        drain("post_rst");

        // Random traffic with random lane counts and bursty reads.
        words_left = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (!bus.in_valid && (cyc < 3000 || words_left != 0) && $urandom_range(0, 3) != 0) begin
                if (words_left == 0) words_left = $urandom_range(1, 3);
                bus.in_data = $urandom;
                bus.in_strb = 4'($urandom);
                bus.in_last = words_left == 1;
                bus.in_valid = 1'b1;
                words_left--;
            end
            reg_lanes_number = 2'($urandom);
            rd = (cyc % 400 < 200) ? 4'($urandom) & 4'($urandom) : 4'($urandom);
            check_pops(rd, "rnd");
            acc = bus.in_valid && bus.in_ready;
            if (acc) model_accept(bus.in_data, bus.in_strb, bus.in_last);
            bus.lane_fifo_read = rd;
            nxt;
            bus.lane_fifo_read = 4'b0;
            if (acc) bus.in_valid = 1'b0;
            if (cyc >= 3000 && words_left == 0 && !bus.in_valid) break;
        end
        chk("rnd_finished", bus.in_valid, 0);
        drain("rnd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dsi_byte_distributor.md
DSI_BYTE_DISTRIBUTOR -- requirements
Module: dsi_byte_distributor

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, per-lane FIFO entry count; power of two, >= 4.
REQ-002 clk_sys  in  1  system clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 reg_lanes_number  in  2  active lanes minus one (0..3 -> 1..4 lanes, L).
REQ-005 in_data  in  32  packet word; byte k = in_data[8k+7:8k].
REQ-006 in_strb  in  4  byte-valid strobes, bit k qualifies byte k.
REQ-007 in_valid  in  1  word present.
REQ-008 in_last  in  1  word is final word of packet.
REQ-009 in_ready  out  1  word accepted on an edge where in_valid & in_ready.
REQ-010 lane_fifo_data  out  36  lane i head entry at [9i+8:9i] = {eop, byte}; show-ahead.
REQ-011 lane_fifo_empty  out  4  lane i FIFO empty.
REQ-012 lane_fifo_read  in  4  pop lane i head; ignored when empty.
REQ-013 busy  out  1  high while any accepted byte or EOP is not yet written to a FIFO.

Function
REQ-014 L SHALL be sampled from reg_lanes_number on the first accepted word of a packet and held until that packet's EOP is written.
REQ-015 Only bytes with strobe set SHALL be sent, ascending byte index; packet byte n SHALL go to lane (n mod L), n counting from 0 at packet start.
REQ-016 FSM states: IDLE (holding register empty), DISPATCH (held bytes remain), EOP (end marker pending).
REQ-017 IDLE -> DISPATCH on accept with nonzero strobe; IDLE -> EOP on accept with in_strb=0 and in_last=1; strobe 0 without last: accepted, nothing written, stay IDLE.
REQ-018 In DISPATCH each cycle SHALL form a group of min(L, remaining held bytes) consecutive bytes, one per distinct lane.
REQ-019 A group SHALL be written at the edge only if every target FIFO is not full (full evaluated before same-cycle pops); otherwise whole group stalls, none written.
REQ-020 After last group: -> EOP if word had in_last, else -> IDLE, or stay DISPATCH if a new word is accepted the same edge.
REQ-021 In EOP, entry {1, 8'h00} SHALL be written to all L active lanes in one edge, only when none of them is full; then -> IDLE.
REQ-022 in_ready SHALL be 1 in IDLE, and in DISPATCH only when the current group is written this edge, empties the holding register, and held word is not last; 0 in EOP.
REQ-023 Latency: word accepted at edge N, no stall -> first group written at edge N+1, lane_fifo_empty falls after edge N+1.
REQ-024 Data entries SHALL carry eop=0; lanes with index >= L SHALL never be written.
REQ-025 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH; full = MSB differs, rest equal; simultaneous pop and push on non-full FIFO keeps count.
REQ-026 Changes of reg_lanes_number mid-packet SHALL have no effect until next packet.

Reset
REQ-027 On rst_n low: state IDLE, holding register cleared, all FIFOs empty, byte counter 0.
REQ-028 Reset values: in_ready=0 while rst_n low, 1 first cycle after release; lane_fifo_empty=4'hF; lane_fifo_data=0; busy=0.
REQ-029 Reset mid-packet SHALL discard all held and queued bytes; no EOP emitted.

Verification
REQ-030 L=4, one word 32'h44332211 strb F last -> lanes 0..3 get 11,22,33,44 at edge N+1, then {1,00} on all four at N+2.
REQ-031 L=1, words 0xDDCCBBAA strb F then 0x000000EE strb 1 last -> lane 0 sequence AA,BB,CC,DD,EE,EOP; in_ready low 3 cycles per 4-byte word; lanes 1..3 stay empty.
REQ-032 L=3, 7-byte packet 01..07 -> lane0 01,04,07,EOP; lane1 02,05,EOP; lane2 03,06,EOP.
REQ-033 L=2, lane 1 FIFO filled to FIFO_DEPTH, no reads, 2-byte word -> group stalls, lane 0 gets nothing, busy=1; one pop on lane 1 -> both bytes written next edge.
REQ-034 strb 4'b1010 data 0xDDCCBBAA, L=2 -> lane0 BB, lane1 DD; strb 0 last alone -> EOP only on both lanes.
REQ-035 rst_n low while DISPATCH holds 3 bytes -> all empty flags 1, busy 0; next packet byte 0 lands on lane 0.
